// File: rtl/spmv_stream.sv
// spmv_stream: sparse-matrix x dense-vector accumulator with a row-by-row drain
module spmv_stream #(
  parameter int N = 32,
  parameter int IDX_W = $clog2(N),
  parameter int DW = 8,
  parameter int ACC_W = 2*DW+IDX_W,
  parameter bit SKIP_ZERO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             weight_valid,
  input  logic [IDX_W-1:0] in_row,
  input  logic [IDX_W-1:0] in_col,
  input  logic [DW-1:0]    in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_row,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, VEC, MAT, DRAIN} state_t;
  state_t state, state_nxt;
  logic [N-1:0][DW-1:0] vec;
  logic [N-1:0][ACC_W-1:0] acc;
  logic [IDX_W-1:0] base, nxt;
  logic [2*DW-1:0] prod;
  logic vec_we, acc_we, load, xfer, done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = (state == IDLE || state == VEC) ? (in_valid ? VEC : weight_valid ? MAT : state) :
                state == MAT ? (weight_valid ? MAT : DRAIN) :
                done ? IDLE : DRAIN;
  end
  // out_row doubles as the drain pointer; the search picks the next row to emit
  always_comb begin
    busy = state != IDLE;
    xfer = out_valid && out_ready;
    done = xfer && out_last;
    vec_we = in_valid && (state == IDLE || state == VEC);
    acc_we = weight_valid && (state == MAT || ((state == IDLE || state == VEC) && !in_valid));
    load = (state == MAT && !weight_valid) || (xfer && !out_last);
    base = state == MAT ? '0 : out_row + 1'b1;
    prod = {{DW{1'b0}}, in_data} * {{DW{1'b0}}, vec[in_col]};
    nxt = IDX_W'(N-1);
    for (int i = N-1; i >= 0; i--)
      if (i >= int'(base) && (!SKIP_ZERO || acc[i] != '0)) nxt = IDX_W'(i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vec <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      out_row <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (done) begin
      vec <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      out_row <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      if (vec_we) vec[in_row] <= in_data;
      if (acc_we) acc[in_row] <= acc[in_row] + ACC_W'(prod);
      if (load) begin
        out_valid <= 1'b1;
        out_row <= nxt;
        out_data <= acc[nxt];
        out_last <= nxt == IDX_W'(N-1);
      end
    end
endmodule

// File: tb/tb_spmv_stream.sv
// tb_spmv_stream: randomized scoreboard bench driving a plain and a zero-skipping instance in parallel
module tb_spmv_stream;
  localparam int N = 32, IDX_W = 5, DW = 8, ACC_W = 21;
  typedef struct {
    logic [IDX_W-1:0] row;
    logic [ACC_W-1:0] data;
    logic             last;
  } beat_t;
  logic clk = 0, rst_n = 1, in_valid = 0, weight_valid = 0, out_ready = 1;
  logic [IDX_W-1:0] in_row = '0, in_col = '0;
  logic [DW-1:0] in_data = '0;
  logic ov0, ov1, ol0, ol1, bz0, bz1;
  logic [IDX_W-1:0] or0, or1;
  logic [ACC_W-1:0] od0, od1;
  beat_t q0[$], q1[$];
  longint mvec[N], macc[N];
  bit in_mat = 0;
  bit stalled[2] = '{0, 0};
  int n_chk = 0, n_fail = 0, mode = 0, cyc = 0;
  logic [3:0] rpat = 4'b1001;

  spmv_stream #(.N(N), .SKIP_ZERO(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .weight_valid(weight_valid),
    .in_row(in_row), .in_col(in_col), .in_data(in_data), .out_ready(out_ready),
    .out_valid(ov0), .out_row(or0), .out_data(od0), .out_last(ol0), .busy(bz0));
  spmv_stream #(.N(N), .SKIP_ZERO(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .weight_valid(weight_valid),
    .in_row(in_row), .in_col(in_col), .in_data(in_data), .out_ready(out_ready),
    .out_valid(ov1), .out_row(or1), .out_data(od1), .out_last(ol1), .busy(bz1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // out_ready: always 1, the 1,0,0,1 pattern, random, or stop on row 12
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? rpat[cyc % 4] :
                mode == 2 ? 1'($urandom % 2) : !(ov0 && or0 == IDX_W'(12));
  end

  task automatic mon(input int k, input logic v, input logic [IDX_W-1:0] r,
                     input logic [ACC_W-1:0] d, input logic l);
    beat_t e;
    if (stalled[k]) chk($sformatf("hold_valid%0d", k), v, 1);
    if (v) begin
      if ((k == 0 ? q0.size() : q1.size()) == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_beat%0d: got row %0d, expected no beat", k, r);
      end else begin
        e = k == 0 ? q0[0] : q1[0];
        chk($sformatf("row%0d", k), r, e.row);
        chk($sformatf("data%0d_r%0d", k, e.row), d, e.data);
        chk($sformatf("last%0d_r%0d", k, e.row), l, e.last);
        if (out_ready) begin
          if (k == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
        end
      end
    end
    stalled[k] = v && !out_ready;
  endtask

  always @(negedge clk) if (rst_n) begin
    mon(0, ov0, or0, od0, ol0);
    mon(1, ov1, or1, od1, ol1);
  end

  task automatic drive(input logic iv, input logic wv, input int r, input int c, input int d);
    in_valid = iv;
    weight_valid = wv;
    in_row = r[IDX_W-1:0];
    in_col = c[IDX_W-1:0];
    in_data = d[DW-1:0];
    if (iv && !in_mat) mvec[r] = d;
    else if (wv) begin
      macc[r] += longint'(d) * mvec[c];
      in_mat = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      mvec[i] = 0;
      macc[i] = 0;
    end
    in_mat = 0;
  endtask

  task automatic end_frame(input bit pulse);
    beat_t b;
    in_valid = 0;
    weight_valid = 0;
    for (int r = 0; r < N; r++) begin
      b.row = IDX_W'(r);
      b.data = ACC_W'(macc[r]);
      b.last = r == N-1;
      q0.push_back(b);
      if (macc[r] != 0 || r == N-1) q1.push_back(b);
    end
    clear_model();
    @(negedge clk);
    chk("latency_pre0", ov0, 0);
    chk("latency_pre1", ov1, 0);
    @(negedge clk);
    chk("latency0", ov0, 1);
    chk("latency1", ov1, 1);
    if (pulse) begin
      in_valid = 1;
      in_row = 1;
      in_data = 99;
      @(posedge clk);
      #1;
      in_valid = 0;
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d beats pending, expected 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
    chk("busy_after0", bz0, 0);
    chk("busy_after1", bz1, 0);
    chk("valid_after0", ov0, 0);
  endtask

  task automatic check_reset_state();
    chk("rst_valid0", ov0, 0); chk("rst_row0", or0, 0); chk("rst_data0", od0, 0);
    chk("rst_last0", ol0, 0); chk("rst_busy0", bz0, 0);
    chk("rst_valid1", ov1, 0); chk("rst_row1", or1, 0); chk("rst_data1", od1, 0);
    chk("rst_last1", ol1, 0); chk("rst_busy1", bz1, 0);
  endtask

  task automatic rand_frame();
    int n;
    for (int i = 0; i < N; i++)
      if ($urandom_range(0, 2) == 0) drive(1, 0, i, 0, $urandom_range(0, 255));
    n = $urandom_range(1, 40);
    for (int j = 0; j < n; j++)
      drive(0, 1, $urandom_range(0, 3) * 8 + $urandom_range(0, 1), $urandom_range(0, N-1),
            $urandom_range(0, 255));
  endtask

  initial begin
    int t;
    clear_model();
    #2 rst_n = 0;
    #20 check_reset_state();
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < N; i++) drive(1, 0, i, 0, i + 1);
    drive(0, 1, 3, 0, 2);
    drive(0, 1, 3, 5, 4);
    drive(0, 1, 7, 31, 255);
    end_frame(0);
    wait_done();
    for (int i = 0; i < N; i++) drive(1, 0, i, 0, 255);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) drive(0, 1, r, c, 255);
    end_frame(0);
    wait_done();
    mode = 1;
    rand_frame();
    end_frame(0);
    wait_done();
    mode = 0;
    for (int i = 0; i < N; i++) drive(1, 0, i, 0, i + 1);
    drive(0, 1, 4, 2, 3);
    drive(0, 1, 10, 9, 1);
    end_frame(0);
    wait_done();
    drive(1, 0, 1, 0, 5);
    drive(1, 1, 2, 3, 9);
    drive(0, 1, 2, 1, 3);
    drive(0, 1, 2, 1, 3);
    drive(1, 1, 5, 1, 4);
    drive(0, 1, 6, 2, 1);
    end_frame(1);
    wait_done();
    drive(0, 1, 5, 3, 200);
    end_frame(0);
    wait_done();
    mode = 2;
    repeat (4) begin
      rand_frame();
      end_frame(0);
      wait_done();
    end
    mode = 3;
    drive(1, 0, 0, 0, 2);
    drive(1, 0, 3, 0, 7);
    drive(0, 1, 20, 3, 5);
    drive(0, 1, 0, 0, 4);
    drive(0, 1, 12, 3, 1);
    end_frame(0);
    t = 0;
    while (!(ov0 && or0 == IDX_W'(12)) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("stall_on_row12", t < 500, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    stalled = '{0, 0};
    q0.delete();
    q1.delete();
    #1 check_reset_state();
    @(negedge clk) rst_n = 1;
    mode = 0;
    drive(1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 9);
    drive(0, 1, 1, 5, 1);
    end_frame(0);
    wait_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spmv_stream.md
Name: spmv_stream

Overview:
- Parametrised sparse-matrix × dense-vector engine; next generation of the fixed 32-entry SPMV block.
- Loads a dense vector of N entries, then accumulates a stream of sparse (row, col, weight) triplets into per-row accumulators.
- Drains the results row by row over a valid/ready output handshake.
- Optional zero-row skipping. Sits between the sparse-data loader and the result writeback stage.

Parameters:
- N, 32, vector length and matrix dimension (N ≥ 2).
- IDX_W, $clog2(N), row/column index width.
- DW, 8, unsigned width of vector entries and matrix weights.
- ACC_W, 2*DW+IDX_W, accumulator and output width; sized so N maximal products cannot overflow.
- SKIP_ZERO, 0, when 1 the drain omits rows whose accumulator is 0, except row N-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- in_valid  in  1  vector entry beat: vec[in_row] ← in_data.
- weight_valid  in  1  matrix triplet beat (in_row, in_col, in_data).
- in_row  in  IDX_W  vector index, or matrix row.
- in_col  in  IDX_W  matrix column; ignored for vector beats.
- in_data  in  DW  unsigned vector value or weight.
- out_ready  in  1  downstream accepts a result beat.
- out_valid  out  1  result beat valid.
- out_row  out  IDX_W  row index of the result.
- out_data  out  ACC_W  accumulated row result.
- out_last  out  1  marks the final beat of a frame (row N-1).
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async): state = IDLE; out_valid, out_row, out_data, out_last, busy = 0; all vec and acc entries = 0; drain pointer = 0. Reset mid-frame discards the frame entirely.
- Storage: vec[0..N-1] is DW bits wide; acc[0..N-1] is ACC_W bits wide. Unwritten vec entries read as 0.
- FSM states: IDLE, VEC, MAT, DRAIN.
  - IDLE: in_valid → write vec, go VEC. weight_valid → accumulate against the all-zero vector, go MAT.
  - VEC: in_valid → write vec; rewriting an index overwrites it. weight_valid (with in_valid low) → accumulate, go MAT.
  - MAT: weight_valid → acc[in_row] ← acc[in_row] + in_data*vec[in_col], single-cycle. Duplicate (row, col) triplets sum. The first sampled cycle with weight_valid low → DRAIN, and the first beat is loaded on that same edge.
  - DRAIN: emits results (see drain rules below).
- Input priority: in_valid and weight_valid high together in IDLE/VEC → in_valid wins and the weight is dropped. In MAT, in_valid is ignored; weight_valid still applies. In DRAIN, both inputs are ignored. The source must hold both low until busy falls.
- Latency: out_valid rises on the edge after the last weight beat, i.e. one cycle after weight_valid deasserts.
- Drain beat: out_row = pointer p, out_data = acc[p], out_last = (p == N-1).
  - A transfer occurs on a cycle with out_valid && out_ready.
  - While stalled, out_row, out_data and out_last hold stable.
  - out_valid never drops without a transfer.
- Next row after a transfer: SKIP_ZERO=0 → p+1. SKIP_ZERO=1 → lowest index > p with nonzero acc; if none, N-1. The first beat uses the same rule starting from index 0 inclusive.
- Row N-1 is always emitted, so every frame ends with exactly one out_last beat.
- On the transfer of the out_last beat:
  - out_valid, out_last → 0 next cycle;
  - all acc and vec entries cleared in that same edge;
  - p → 0; state → IDLE; busy → 0.
  - A new frame may start on the following cycle.
- Arithmetic: all operands unsigned. The product is 2*DW bits wide, zero-extended to ACC_W. No saturation is needed within one frame by construction.

Test Plan:
- Basic, N=32, SKIP_ZERO=0, out_ready=1: vec[i]=i+1; triplets (3,0,2), (3,5,4), (7,31,255) → 32 beats on consecutive cycles; row3=26, row7=8160, all other rows 0; out_last only on row 31; busy low the cycle after.
- Overflow bound: every vec entry 255; every (r,c) pair with weight 255 → each row = 2080800 (fits 21 bits); no wrap.
- Backpressure: toggle out_ready 1,0,0,1 per cycle during the drain → each row delivered exactly once, in order; out_data stable throughout each stall.
- SKIP_ZERO=1: only rows 4 and 10 nonzero → beats row4, row10, row31 (data 0, out_last=1); exactly 3 beats.
- Collisions: in_valid and weight_valid together in VEC → vec written, weight dropped. in_valid during MAT/DRAIN → no effect. Duplicate triplet (2,1,3)×2 with vec[1]=5 → row2=30.
- Reset mid-drain while stalled on row 12, then a fresh frame vec[0]=1 with (0,0,9) → out row0=9 and all other rows 0, proving vec and acc were cleared.
